// File: rtl/treehash_pkg.sv
// Shared types and constants for the treehash controller and its height shadow stack.
package treehash_pkg;

    localparam int NODE_WIDTH_DEF   = 32;
    localparam int TREE_HEIGHT_DEF  = 4;
    localparam int HEIGHT_WIDTH_DEF = $clog2(TREE_HEIGHT_DEF + 1);

    typedef logic [NODE_WIDTH_DEF-1:0]   node_t;
    typedef logic [HEIGHT_WIDTH_DEF-1:0] height_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_LEAF,
        S_CHECK,
        S_POP,
        S_POP_WAIT,
        S_HASH_REQ,
        S_HASH_WAIT,
        S_PUSH,
        S_DONE
    } state_e;

    function automatic int LEAF_COUNT(input int tree_height);
        return 1 << tree_height;
    endfunction

endpackage

// File: rtl/treehash_height_shadow.sv
// Height stack mirroring the external node stack; top is readable in the same cycle.
module treehash_height_shadow #(
    parameter int DEPTH = 4,
    parameter int HW    = 3,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [HW-1:0] push_h,
    output logic [HW-1:0] top,
    output logic [CW-1:0] count,
    output logic          empty
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [HW-1:0] mem [DEPTH];
    logic [CW-1:0] count_m1;
    logic          can_push;

    assign empty    = (count == '0);
    assign can_push = (count != CW'(DEPTH));
    assign count_m1 = count - CW'(1);
    assign top      = empty ? '0 : mem[count_m1[IW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && can_push) begin
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count_m1;
        end
    end

    // Entries above count are never read, so the array itself needs no reset.
    always_ff @(posedge clock) begin
        if (push && can_push && !clear) begin
            mem[count[IW-1:0]] <= push_h;
        end
    end

endmodule

// File: rtl/treehash_ctrl.sv
// Treehash controller: folds a leaf stream into a Merkle root using an external node stack and hash core.
module treehash_ctrl
    import treehash_pkg::*;
#(
    parameter int NODE_WIDTH   = 32,
    parameter int TREE_HEIGHT  = 4,
    parameter int HEIGHT_WIDTH = $clog2(TREE_HEIGHT + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NODE_WIDTH-1:0]   leaf_data,
    input  logic                    leaf_valid,
    output logic                    leaf_ready,
    output logic                    stk_push,
    output logic [NODE_WIDTH-1:0]   stk_push_data,
    output logic                    stk_pop,
    input  logic [NODE_WIDTH-1:0]   stk_pop_data,
    input  logic                    stk_full,
    output logic                    hash_req_valid,
    input  logic                    hash_req_ready,
    output logic [NODE_WIDTH-1:0]   hash_left,
    output logic [NODE_WIDTH-1:0]   hash_right,
    output logic [HEIGHT_WIDTH-1:0] hash_height,
    input  logic                    hash_resp_valid,
    input  logic [NODE_WIDTH-1:0]   hash_resp_data,
    output logic                    root_valid,
    output logic [NODE_WIDTH-1:0]   root_data,
    output logic                    busy,
    output logic                    error
);
    localparam int LEAVES = LEAF_COUNT(TREE_HEIGHT);
    localparam int LCW    = $clog2(LEAVES + 1);
    localparam int SCW    = $clog2(TREE_HEIGHT + 1);

    state_e                  state, state_nxt;
    logic [NODE_WIDTH-1:0]   cur_node, left_reg, root_q;
    logic [HEIGHT_WIDTH-1:0] cur_h;
    logic [LCW-1:0]          leaf_cnt;
    logic                    err_q;

    logic                    sh_clear, sh_push, sh_pop, sh_empty, sh_full;
    logic [HEIGHT_WIDTH-1:0] sh_top;
    logic [SCW-1:0]          sh_count;
    logic                    overflow;

    treehash_height_shadow #(
        .DEPTH (TREE_HEIGHT),
        .HW    (HEIGHT_WIDTH)
    ) u_shadow (
        .clock  (clock),
        .reset  (reset),
        .clear  (sh_clear),
        .push   (sh_push),
        .pop    (sh_pop),
        .push_h (cur_h),
        .top    (sh_top),
        .count  (sh_count),
        .empty  (sh_empty)
    );

    assign sh_full       = (sh_count == SCW'(TREE_HEIGHT));
    assign overflow      = stk_full || sh_full;
    assign busy          = (state != S_IDLE);
    assign stk_push_data = cur_node;
    assign hash_left     = left_reg;
    assign hash_right    = cur_node;
    assign hash_height   = cur_h;
    assign root_data     = root_q;
    assign error         = err_q;

    always_comb begin
        state_nxt      = state;
        leaf_ready     = 1'b0;
        stk_push       = 1'b0;
        stk_pop        = 1'b0;
        hash_req_valid = 1'b0;
        root_valid     = 1'b0;
        sh_clear       = 1'b0;
        sh_push        = 1'b0;
        sh_pop         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    sh_clear  = 1'b1;
                    state_nxt = S_WAIT_LEAF;
                end
            end
            S_WAIT_LEAF: begin
                leaf_ready = 1'b1;
                if (leaf_valid) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (!sh_empty && (sh_top == cur_h))            state_nxt = S_POP;
                else if (cur_h == HEIGHT_WIDTH'(TREE_HEIGHT))  state_nxt = S_DONE;
                else                                           state_nxt = S_PUSH;
            end
            S_POP: begin
                stk_pop   = 1'b1;
                sh_pop    = 1'b1;
                state_nxt = S_POP_WAIT;
            end
            S_POP_WAIT: state_nxt = S_HASH_REQ;
            S_HASH_REQ: begin
                hash_req_valid = 1'b1;
                if (hash_req_ready) state_nxt = S_HASH_WAIT;
            end
            S_HASH_WAIT: begin
                if (hash_resp_valid) state_nxt = S_CHECK;
            end
            S_PUSH: begin
                if (overflow) begin
                    state_nxt = S_IDLE;
                end else begin
                    stk_push  = 1'b1;
                    sh_push   = 1'b1;
                    state_nxt = S_WAIT_LEAF;
                end
            end
            S_DONE: begin
                root_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cur_node <= '0;
            cur_h    <= '0;
            left_reg <= '0;
            leaf_cnt <= '0;
            root_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        leaf_cnt <= '0;
                        err_q    <= 1'b0;
                    end
                end
                S_WAIT_LEAF: begin
                    if (leaf_valid) begin
                        cur_node <= leaf_data;
                        cur_h    <= '0;
                        leaf_cnt <= leaf_cnt + LCW'(1);
                    end
                end
                // Capture the root on the way into DONE so it is valid alongside root_valid.
                S_CHECK: begin
                    if (state_nxt == S_DONE) root_q <= cur_node;
                end
                S_POP_WAIT: left_reg <= stk_pop_data;
                S_HASH_WAIT: begin
                    if (hash_resp_valid) begin
                        cur_node <= hash_resp_data;
                        cur_h    <= cur_h + HEIGHT_WIDTH'(1);
                    end
                end
                S_PUSH: begin
                    if (overflow) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_treehash_ctrl.sv
// Directed bench for treehash_ctrl at TREE_HEIGHT=2 with a behavioural stack and a left+right+height hash core.
module tb_treehash_ctrl;
    localparam int NW = 32;
    localparam int TH = 2;
    localparam int HW = $clog2(TH + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] leaf_data = '0;
    logic          leaf_valid = 1'b0;
    logic          leaf_ready;
    logic          stk_push, stk_pop, stk_full;
    logic [NW-1:0] stk_push_data;
    logic [NW-1:0] stk_pop_data;
    logic          hash_req_valid, hash_req_ready;
    logic [NW-1:0] hash_left, hash_right;
    logic [HW-1:0] hash_height;
    logic          hash_resp_valid;
    logic [NW-1:0] hash_resp_data;
    logic          root_valid;
    logic [NW-1:0] root_data;
    logic          busy, error;

    logic          ready_en   = 1'b1;
    logic          force_full = 1'b0;

    int checks   = 0;
    int failures = 0;

    treehash_ctrl #(.NODE_WIDTH(NW), .TREE_HEIGHT(TH)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .leaf_data       (leaf_data),
        .leaf_valid      (leaf_valid),
        .leaf_ready      (leaf_ready),
        .stk_push        (stk_push),
        .stk_push_data   (stk_push_data),
        .stk_pop         (stk_pop),
        .stk_pop_data    (stk_pop_data),
        .stk_full        (stk_full),
        .hash_req_valid  (hash_req_valid),
        .hash_req_ready  (hash_req_ready),
        .hash_left       (hash_left),
        .hash_right      (hash_right),
        .hash_height     (hash_height),
        .hash_resp_valid (hash_resp_valid),
        .hash_resp_data  (hash_resp_data),
        .root_valid      (root_valid),
        .root_data       (root_data),
        .busy            (busy),
        .error           (error)
    );

    always #5 clock = ~clock;

    // Stack model: capacity TH, pop data returned the cycle after the pop strobe.
    logic [NW-1:0] stk_mem [0:7];
    int sp = 0;
    int peak = 0;
    assign stk_full = (sp >= TH) || force_full;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp           <= 0;
            stk_pop_data <= '0;
        end else if (stk_push) begin
            if (sp < 8) stk_mem[sp] <= stk_push_data;
            sp <= sp + 1;
        end else if (stk_pop) begin
            if (sp > 0) begin
                stk_pop_data <= stk_mem[sp-1];
                sp           <= sp - 1;
            end
        end
    end

    always @(posedge clock) if (sp > peak) peak <= sp;

    // Hash core model: accepts when ready, answers one cycle later.
    assign hash_req_ready = ready_en;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            hash_resp_valid <= 1'b0;
            hash_resp_data  <= '0;
        end else begin
            hash_resp_valid <= 1'b0;
            if (hash_req_valid && hash_req_ready) begin
                hash_resp_valid <= 1'b1;
                hash_resp_data  <= hash_left + hash_right + NW'(hash_height);
            end
        end
    end

    // Monitors.
    logic [NW-1:0] push_vals [0:63];
    int push_total = 0;
    int pop_total  = 0;
    int overlap    = 0;
    int ready_viol = 0;
    int root_cnt   = 0;
    logic [NW-1:0] root_last = '0;

    always @(posedge clock) begin
        if (reset) begin
            if (stk_push) begin
                if (push_total < 64) push_vals[push_total] <= stk_push_data;
                push_total <= push_total + 1;
            end
            if (stk_pop) pop_total <= pop_total + 1;
            if (stk_push && stk_pop) overlap <= overlap + 1;
            if (leaf_ready && (stk_push || stk_pop || hash_req_valid || root_valid))
                ready_viol <= ready_viol + 1;
            if (root_valid) begin
                root_cnt  <= root_cnt + 1;
                root_last <= root_data;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_leaf(input logic [NW-1:0] v, input int gap);
        bit ok = 1'b0;
        repeat (gap) @(negedge clock);
        leaf_valid = 1'b1;
        leaf_data  = v;
        for (int i = 0; i < 100; i++) begin
            if (leaf_ready) begin
                ok = 1'b1;
                @(posedge clock);
                #1;
                leaf_valid = 1'b0;
                break;
            end
            @(negedge clock);
        end
        if (!ok) leaf_valid = 1'b0;
        check("leaf_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_root(input int exp_cnt);
        for (int i = 0; i < 300; i++) begin
            if (root_cnt >= exp_cnt) break;
            @(negedge clock);
        end
        check("root_pulse_count", 64'(root_cnt), 64'(exp_cnt));
    endtask

    task automatic wait_hash_req();
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (hash_req_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("hash_req_seen", 64'(seen), 64'd1);
    endtask

    int base;

    initial begin
        // Reset state
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_root_data", 64'(root_data), 64'd0);
        check("rst_leaf_ready", 64'(leaf_ready), 64'd0);
        check("rst_outputs", 64'({stk_push, stk_pop, hash_req_valid, root_valid}), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Plain run 1,2,3,4 -> 11
        do_start();
        check("busy_after_start", 64'(busy), 64'd1);
        for (int k = 1; k <= 4; k++) send_leaf(NW'(k), 0);
        wait_root(1);
        check("run1_root", 64'(root_last), 64'd11);
        check("run1_stack_empty", 64'(sp), 64'd0);
        check("run1_push_count", 64'(push_total), 64'd3);
        check("run1_push0", 64'(push_vals[0]), 64'd1);
        check("run1_push1", 64'(push_vals[1]), 64'd3);
        check("run1_push2", 64'(push_vals[2]), 64'd3);
        check("run1_pop_count", 64'(pop_total), 64'd3);
        check("run1_peak", 64'(peak), 64'd2);
        @(negedge clock);
        check("run1_idle", 64'(busy), 64'd0);
        check("run1_root_held", 64'(root_data), 64'd11);

        // Hash core stalls 5 cycles on the first request
        ready_en = 1'b0;
        do_start();
        send_leaf(NW'(1), 0);
        send_leaf(NW'(2), 0);
        wait_hash_req();
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", 64'(hash_req_valid), 64'd1);
            check("stall_operands", {hash_left, hash_right}, {32'd1, 32'd2});
            check("stall_height", 64'(hash_height), 64'd0);
            check("stall_leaf_ready", 64'(leaf_ready), 64'd0);
            @(negedge clock);
        end
        ready_en = 1'b1;
        send_leaf(NW'(3), 0);
        send_leaf(NW'(4), 0);
        wait_root(2);
        check("stall_root", 64'(root_last), 64'd11);

        // Gapped leaves with a stray start while busy
        base = push_total;
        do_start();
        send_leaf(NW'(1), 3);
        send_leaf(NW'(2), 2);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        send_leaf(NW'(3), 4);
        send_leaf(NW'(4), 1);
        wait_root(3);
        check("gap_root", 64'(root_last), 64'd11);
        check("gap_push_count", 64'(push_total - base), 64'd3);
        check("leaf_ready_exclusive", 64'(ready_viol), 64'd0);

        // Asynchronous reset during HASH_WAIT of the second leaf
        do_start();
        send_leaf(NW'(1), 0);
        send_leaf(NW'(2), 0);
        wait_hash_req();
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_root_data", 64'(root_data), 64'd0);
        check("mid_rst_datapath", {hash_left, stk_push_data}, 64'd0);
        check("mid_rst_strobes", 64'({stk_push, stk_pop, hash_req_valid, root_valid, leaf_ready, error}), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        do_start();
        for (int k = 1; k <= 4; k++) send_leaf(NW'(k), 0);
        wait_root(4);
        check("post_rst_root", 64'(root_last), 64'd11);
        check("post_rst_stack_empty", 64'(sp), 64'd0);

        // Stack full at the first push
        base = push_total;
        force_full = 1'b1;
        do_start();
        send_leaf(NW'(5), 0);
        repeat (4) @(negedge clock);
        check("full_error", 64'(error), 64'd1);
        check("full_idle", 64'(busy), 64'd0);
        check("full_no_push", 64'(push_total - base), 64'd0);
        force_full = 1'b0;
        do_start();
        check("start_clears_error", 64'(error), 64'd0);
        for (int k = 1; k <= 4; k++) send_leaf(NW'(k), 0);
        wait_root(5);
        check("after_full_root", 64'(root_last), 64'd11);
        check("push_pop_never_overlap", 64'(overlap), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/treehash_ctrl.md
Name: treehash_ctrl

Overview:
- Merkle-tree (treehash) controller for the hash-based signature datapath; it sits directly upstream of the node stack.
- Accepts a stream of 2^TREE_HEIGHT leaf digests and pushes or pops tree nodes on the external stack.
- Issues left/right pair-hash requests to an external hash core and emits the root digest.
- The stack stores node values only; node heights are tracked in an internal shadow array.

Parameters:
- NODE_WIDTH, 32, width of a leaf/node digest (equals the stack DATA_WIDTH).
- TREE_HEIGHT, 4, tree height; leaf count = 2^TREE_HEIGHT; max stack occupancy = TREE_HEIGHT.
- HEIGHT_WIDTH, $clog2(TREE_HEIGHT+1), width of the height fields.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse in IDLE begins a tree; ignored in any other state.
- leaf_data  in  NODE_WIDTH  leaf digest.
- leaf_valid  in  1  leaf offered.
- leaf_ready  out  1  high only in WAIT_LEAF; a leaf transfers when valid&&ready.
- stk_push  out  1  one-cycle push strobe.
- stk_push_data  out  NODE_WIDTH  value pushed; valid while stk_push is high.
- stk_pop  out  1  one-cycle pop strobe.
- stk_pop_data  in  NODE_WIDTH  popped value; valid the cycle after stk_pop.
- stk_full  in  1  stack full flag.
- hash_req_valid  out  1  pair-hash request.
- hash_req_ready  in  1  hash core accepts the request.
- hash_left, hash_right  out  NODE_WIDTH each  operands.
- hash_height  out  HEIGHT_WIDTH  height of the operands (tweak).
- hash_resp_valid  in  1  one-cycle result strobe.
- hash_resp_data  in  NODE_WIDTH  result.
- root_valid  out  1  one-cycle pulse with the root.
- root_data  out  NODE_WIDTH  root digest; held until the next start.
- busy  out  1  high in every state except IDLE.
- error  out  1  sticky overflow flag; cleared by start or reset.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - All outputs are 0: root_data=0, error=0, busy=0.
  - Leaf counter, shadow count and the cur_node/cur_h registers are cleared.
- Reset mid-tree: aborts immediately. The external stack is not popped; it must be reset alongside this block.
- FSM states: IDLE, WAIT_LEAF, CHECK, POP, POP_WAIT, HASH_REQ, HASH_WAIT, PUSH, DONE.
- IDLE: on start, clear the counters and error, then go to WAIT_LEAF.
- WAIT_LEAF: on a leaf transfer, cur_node=leaf_data, cur_h=0, leaf_cnt++, go to CHECK.
- CHECK (one cycle, decision only), first matching rule wins:
  - If shadow count>0 and shadow top height==cur_h, go to POP.
  - Else if cur_h==TREE_HEIGHT, go to DONE.
  - Else go to PUSH.
- POP: stk_pop=1 for exactly one cycle; shadow count--; go to POP_WAIT.
- POP_WAIT: left_reg=stk_pop_data; go to HASH_REQ.
- HASH_REQ:
  - Drive hash_req_valid=1 with hash_left=left_reg, hash_right=cur_node, hash_height=cur_h.
  - Hold all request fields stable until hash_req_ready, then go to HASH_WAIT.
- HASH_WAIT: on hash_resp_valid, cur_node=hash_resp_data, cur_h=cur_h+1, go to CHECK. Responses arriving in any other state are ignored.
- PUSH:
  - If stk_full is high, set error and go to IDLE; nothing is pushed.
  - Otherwise stk_push=1 with stk_push_data=cur_node, shadow[count]=cur_h, count++, go to WAIT_LEAF.
- DONE: root_data=cur_node, root_valid=1 for one cycle, go to IDLE; the stack is empty at this point.
- Mutual exclusion: stk_push and stk_pop are never high in the same cycle.
- Occupancy: shadow count never exceeds TREE_HEIGHT; leaf_cnt never exceeds 2^TREE_HEIGHT.
- Latency per merge with a zero-wait hash core: CHECK, POP, POP_WAIT, HASH_REQ, HASH_WAIT = 5 cycles minimum.
- Cost per leaf with no merge: CHECK, PUSH, back to WAIT_LEAF = 3 cycles.
- Arithmetic: cur_h increments without wrap; a height greater than TREE_HEIGHT is unreachable.

Decomposition:
- Package treehash_pkg holds:
  - the FSM state enum;
  - the NODE_WIDTH/HEIGHT_WIDTH typedefs (node_t, height_t);
  - the LEAF_COUNT constant function.
- One natural sub-module: treehash_height_shadow. It is a TREE_HEIGHT-deep height register stack with push, pop, top, count and empty, and a 0-cycle top read.

Test Plan:
- TREE_HEIGHT=2, hash model = left+right+height, leaves 1,2,3,4 -> hashes (1,2,h0)=3, (3,4,h0)=7, (3,7,h1)=11; root_valid pulses once with root_data=11; stack empty afterwards.
- Same run, monitoring the stack -> push sequence 1,3,3 and 3 pops; peak occupancy 2; stk_push and stk_pop never overlap.
- hash_req_ready held low 5 cycles in the first request -> hash_left=1, hash_right=2, hash_height=0 stable throughout; final root still 11.
- leaf_valid toggling with gaps, plus a start pulse while busy -> start ignored; leaf_ready only in WAIT_LEAF; result unchanged.
- reset driven low during HASH_WAIT of the second leaf -> busy=0 and all outputs 0 asynchronously; after a subsequent start, a fresh 1,2,3,4 run gives root 11.
- stk_full forced high at the first PUSH -> error=1, no push, return to IDLE; a later start clears error.
